per_port_demux: RTL and testbench

// - 1-to-N AXI4-Stream packet distributor. It is the transmit-side counterpart of the
//   N-to-1 timestamp arbiter.
// - Takes one merged stream and steers each whole packet to one or more per-port output queues.
// - The destination is a one-hot (or multi-hot) field in tuser, sampled on the first beat only.
// - Sits between the packet generator/pipeline and the per-port TX queues.

---
 rtl/per_port_demux.sv | 154 +++++++++++++++
 tb/tb_per_port_demux.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/per_port_demux.sv
// 1-to-N AXI4-Stream packet distributor: each packet is steered, whole, to the port(s)
// named by a one-/multi-hot destination field in the first beat's tuser.
module per_port_demux #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_NUM_QUEUES       = 5,
  parameter int C_TUSER_DST_POS      = 24
) (
  input  logic                                                axi_aclk,
  input  logic                                                axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]                      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]                    s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]                     s_axis_tuser,
  input  logic                                                s_axis_tvalid,
  output logic                                                s_axis_tready,
  input  logic                                                s_axis_tlast,
  output logic [C_M_NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_grp,
  output logic [C_M_NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_grp,
  output logic [C_M_NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_grp,
  output logic [C_M_NUM_QUEUES-1:0]                           m_axis_tvalid_grp,
  input  logic [C_M_NUM_QUEUES-1:0]                           m_axis_tready_grp,
  output logic [C_M_NUM_QUEUES-1:0]                           m_axis_tlast_grp,
  output logic [31:0]                                         drop_count
);

  localparam int N          = C_M_NUM_QUEUES;
  localparam int DW         = C_M_AXIS_DATA_WIDTH;
  localparam int UW         = C_M_AXIS_TUSER_WIDTH;
  localparam int SW         = DW / 8;
  localparam int FW         = DW + UW + SW + 1;
  localparam int DEPTH_BITS = 2;
  localparam int DEPTH      = 1 << DEPTH_BITS;

  typedef enum logic [1:0] {
    IN_PKT_HEADER = 2'd0,
    IN_PKT_BODY   = 2'd1,
    DROP_BODY     = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   dst_r_reg, dst_r_next;
  logic [31:0]    drop_count_reg, drop_count_next;

  logic [N-1:0]   dst;
  logic [N-1:0]   sel;
  logic [N-1:0]   nearly_full;
  logic [N-1:0]   wr_en;
  logic           sel_ready;
  logic           accept;
  logic [FW-1:0]  din;

  assign dst    = s_axis_tuser[C_TUSER_DST_POS +: N];
  assign sel    = (state_reg == IN_PKT_HEADER) ? dst : dst_r_reg;
  assign din    = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign accept = s_axis_tvalid && s_axis_tready;

  // A multicast beat waits until every selected port has room, so copies stay in step.
  always_comb begin
    sel_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel[i] && nearly_full[i]) sel_ready = 1'b0;
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (!axi_reset) begin
      s_axis_tready = (state_reg == DROP_BODY) || (sel == '0) || sel_ready;
    end
  end

  assign wr_en = (accept && state_reg != DROP_BODY) ? sel : '0;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_reg      <= IN_PKT_HEADER;
      dst_r_reg      <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      dst_r_reg      <= dst_r_next;
      drop_count_reg <= drop_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    dst_r_next      = dst_r_reg;
    drop_count_next = drop_count_reg;
    if (accept) begin
      case (state_reg)
        IN_PKT_HEADER: begin
          if (dst == '0) begin
            if (drop_count_reg != 32'hFFFF_FFFF) drop_count_next = drop_count_reg + 32'd1;
            dst_r_next = '0;
            if (!s_axis_tlast) state_next = DROP_BODY;
          end else if (!s_axis_tlast) begin
            dst_r_next = dst;
            state_next = IN_PKT_BODY;
          end
        end
        IN_PKT_BODY: if (s_axis_tlast) state_next = IN_PKT_HEADER;
        DROP_BODY:   if (s_axis_tlast) state_next = IN_PKT_HEADER;
        default:     state_next = IN_PKT_HEADER;
      endcase
    end
  end

  assign drop_count = drop_count_reg;

  // Per-port fall-through FIFO: the head entry is presented combinationally.
  for (genvar gi = 0; gi < N; gi++) begin : g_port
    logic [FW-1:0]         mem_reg [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_BITS:0]   count_reg;
    logic                  empty;
    logic                  rd_en;
    logic [FW-1:0]         dout;

    assign empty            = (count_reg == '0);
    assign nearly_full[gi]  = (count_reg >= (DEPTH_BITS+1)'(DEPTH));
    assign rd_en            = !empty && m_axis_tready_grp[gi];
    assign dout             = mem_reg[rd_ptr_reg];

    always_ff @(posedge axi_aclk) begin
      if (wr_en[gi]) mem_reg[wr_ptr_reg] <= din;
    end

    always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (wr_en[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (rd_en)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({wr_en[gi], rd_en})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end

    assign m_axis_tdata_grp[gi*DW +: DW] = dout[DW-1:0];
    assign m_axis_tstrb_grp[gi*SW +: SW] = dout[DW +: SW];
    assign m_axis_tuser_grp[gi*UW +: UW] = dout[DW+SW +: UW];
    assign m_axis_tlast_grp[gi]          = dout[FW-1] && !empty;
    assign m_axis_tvalid_grp[gi]         = !empty;
  end

endmodule

// File: tb/tb_per_port_demux.sv
// Randomised and directed bench for per_port_demux, checked every cycle against a
// packet-level queue model of the distributor.
module tb_per_port_demux;
  localparam int N   = 5;
  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int SW  = DW / 8;
  localparam int POS = 24;
  localparam int CAP = 4;

  logic                 clk = 1'b0;
  logic                 axi_reset;
  logic [DW-1:0]        s_axis_tdata;
  logic [SW-1:0]        s_axis_tstrb;
  logic [UW-1:0]        s_axis_tuser;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic [N*DW-1:0]      m_axis_tdata_grp;
  logic [N*SW-1:0]      m_axis_tstrb_grp;
  logic [N*UW-1:0]      m_axis_tuser_grp;
  logic [N-1:0]         m_axis_tvalid_grp;
  logic [N-1:0]         m_axis_tready_grp;
  logic [N-1:0]         m_axis_tlast_grp;
  logic [31:0]          drop_count;

  always #5 clk = ~clk;

  per_port_demux dut (
    .axi_aclk          (clk),
    .axi_reset         (axi_reset),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tstrb      (s_axis_tstrb),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata_grp  (m_axis_tdata_grp),
    .m_axis_tstrb_grp  (m_axis_tstrb_grp),
    .m_axis_tuser_grp  (m_axis_tuser_grp),
    .m_axis_tvalid_grp (m_axis_tvalid_grp),
    .m_axis_tready_grp (m_axis_tready_grp),
    .m_axis_tlast_grp  (m_axis_tlast_grp),
    .drop_count        (drop_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t        mq[N][$];     // expected contents of each port, oldest first
  beat_t        tx_q[$];      // beats still to be offered on the input
  int           errors = 0;
  int           checks = 0;
  bit           checking = 0;
  bit           m_in_body, m_dropping;
  logic [N-1:0] m_dst;
  logic [31:0]  m_drops;
  logic [N-1:0] rdy;
  bit           rst;
  bit           throttle;
  bit           held, present;
  beat_t        cur;
  int           accepted;
  int           pops[N];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic beat_t rand_beat(input logic [N-1:0] dst, input bit first, input bit last,
                                      input int other_dst);
    beat_t b;
    for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom();
    b.s = $urandom();
    for (int w = 0; w < UW/32; w++) b.u[w*32 +: 32] = $urandom();
    if (first) b.u[POS +: N] = dst;
    else if (other_dst >= 0) b.u[POS +: N] = N'(other_dst);
    b.l = last;
    return b;
  endfunction

  task automatic push_pkt(input logic [N-1:0] dst, input int len, input int other_dst);
    for (int i = 0; i < len; i++) tx_q.push_back(rand_beat(dst, i == 0, i == len - 1, other_dst));
  endtask

  task automatic clear_pops();
    for (int i = 0; i < N; i++) pops[i] = 0;
    accepted = 0;
  endtask

  // One clock: drive, compare against the model, advance the model across the edge.
  task automatic step();
    logic         exp_rdy;
    logic [N-1:0] sel;
    bit           acc;
    if (!held) begin
      present = (tx_q.size() > 0) && (!throttle || $urandom_range(0, 4) != 0);
      cur = (tx_q.size() > 0) ? tx_q[0] : rand_beat('0, 1'b0, 1'b0, -1);
    end
    s_axis_tdata      = cur.d;
    s_axis_tstrb      = cur.s;
    s_axis_tuser      = cur.u;
    s_axis_tlast      = cur.l;
    s_axis_tvalid     = present;
    m_axis_tready_grp = rdy;
    axi_reset         = rst;
    #1;
    if (rst) exp_rdy = 1'b0;
    else if (m_dropping) exp_rdy = 1'b1;
    else begin
      sel = m_in_body ? m_dst : cur.u[POS +: N];
      exp_rdy = 1'b1;
      for (int i = 0; i < N; i++) if (sel[i] && mq[i].size() >= CAP) exp_rdy = 1'b0;
    end
    if (checking) begin
      chk("tready", 256'(s_axis_tready), 256'(exp_rdy));
      chk("drop_count", 256'(drop_count), 256'(m_drops));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("tvalid p%0d", i), 256'(m_axis_tvalid_grp[i]), 256'(mq[i].size() > 0));
        if (mq[i].size() > 0) begin
          chk($sformatf("tdata p%0d", i), m_axis_tdata_grp[i*DW +: DW], mq[i][0].d);
          chk($sformatf("tstrb p%0d", i), 256'(m_axis_tstrb_grp[i*SW +: SW]), 256'(mq[i][0].s));
          chk($sformatf("tuser p%0d", i), 256'(m_axis_tuser_grp[i*UW +: UW]), 256'(mq[i][0].u));
          chk($sformatf("tlast p%0d", i), 256'(m_axis_tlast_grp[i]), 256'(mq[i][0].l));
        end else begin
          chk($sformatf("idle tlast p%0d", i), 256'(m_axis_tlast_grp[i]), 256'(0));
        end
      end
    end
    acc = present && exp_rdy;
    for (int i = 0; i < N; i++) if (m_axis_tvalid_grp[i] && rdy[i]) pops[i]++;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_in_body = 0; m_dropping = 0; m_dst = '0; m_drops = '0;
      held = 0;
    end else begin
      for (int i = 0; i < N; i++) if (mq[i].size() > 0 && rdy[i]) void'(mq[i].pop_front());
      if (acc) begin
        accepted++;
        if (m_dropping) begin
          if (cur.l) m_dropping = 0;
        end else if (m_in_body) begin
          for (int i = 0; i < N; i++) if (m_dst[i]) mq[i].push_back(cur);
          if (cur.l) m_in_body = 0;
        end else if (cur.u[POS +: N] == '0) begin
          if (m_drops != 32'hFFFF_FFFF) m_drops++;
          m_dropping = !cur.l;
        end else begin
          for (int i = 0; i < N; i++) if (cur.u[POS + i]) mq[i].push_back(cur);
          if (!cur.l) begin
            m_in_body = 1;
            m_dst = cur.u[POS +: N];
          end
        end
        void'(tx_q.pop_front());
      end
      held = present && !acc;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cycles;
    int sent;
    logic [N-1:0] d;
    rdy = '1; throttle = 0; held = 0; present = 0;
    m_in_body = 0; m_dropping = 0; m_dst = '0; m_drops = '0;
    clear_pops();
    @(negedge clk);
    rst = 1; run(2);
    checking = 1;
    run(1);
    rst = 0;
    chk("reset tvalid", 256'(m_axis_tvalid_grp), 256'(0));
    chk("reset drop_count", 256'(drop_count), 256'(0));
    run(2);

    // T1: single beat to port 2
    clear_pops();
    push_pkt(5'b00100, 1, -1);
    run(1);
    chk("T1 tvalid", 256'(m_axis_tvalid_grp), 256'(5'b00100));
    chk("T1 tlast", 256'(m_axis_tlast_grp), 256'(5'b00100));
    run(3);
    chk("T1 pops p2", 256'(pops[2]), 256'(1));

    // T2: back-to-back 4-beat packets, later beats carry a bogus dst
    clear_pops();
    push_pkt(5'b00001, 4, 5'b00010);
    push_pkt(5'b10000, 4, 5'b00010);
    run(12);
    chk("T2 pops p0", 256'(pops[0]), 256'(4));
    chk("T2 pops p4", 256'(pops[4]), 256'(4));
    chk("T2 pops p1", 256'(pops[1]), 256'(0));

    // T3: multicast with port 3 stalled
    clear_pops();
    rdy = 5'b10111;
    push_pkt(5'b01010, 6, -1);
    run(10);
    chk("T3 accepted", 256'(accepted), 256'(4));
    chk("T3 tready held", 256'(s_axis_tready), 256'(0));
    rdy = '1;
    run(15);
    chk("T3 pops p1", 256'(pops[1]), 256'(6));
    chk("T3 pops p3", 256'(pops[3]), 256'(6));

    // T4: dst==0 packet is dropped, next packet routes
    clear_pops();
    push_pkt(5'b00000, 3, -1);
    run(5);
    chk("T4 drop_count", 256'(drop_count), 256'(1));
    chk("T4 no output", 256'(pops[0] + pops[1] + pops[2] + pops[3] + pops[4]), 256'(0));
    push_pkt(5'b00010, 2, -1);
    run(5);
    chk("T4 pops p1", 256'(pops[1]), 256'(2));

    // T5: reset mid-packet
    clear_pops();
    rdy = '0;
    push_pkt(5'b00001, 6, -1);
    run(2);
    chk("T5 accepted", 256'(accepted), 256'(2));
    rst = 1; run(1); rst = 0;
    tx_q.delete();
    chk("T5 tvalid", 256'(m_axis_tvalid_grp), 256'(0));
    chk("T5 drop_count", 256'(drop_count), 256'(0));
    rdy = '1;
    push_pkt(5'b01000, 2, -1);
    run(6);
    chk("T5 pops p3", 256'(pops[3]), 256'(2));
    chk("T5 pops p0", 256'(pops[0]), 256'(0));

    // T6: random traffic
    throttle = 1;
    sent = 0; cycles = 0;
    while ((sent < 3000 || tx_q.size() > 0) && cycles < 80000) begin
      if (tx_q.size() == 0 && sent < 3000) begin
        d = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 31));
        push_pkt(d, $urandom_range(1, 4), -1);
        sent++;
      end
      for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      step();
      cycles++;
    end
    if (cycles >= 80000) begin
      errors++; checks++;
      $display("FAIL T6 timeout: got cycles=%0d want < 80000", cycles);
    end
    throttle = 0; rdy = '1;
    run(10);
    chk("T6 drained", 256'(m_axis_tvalid_grp), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
